modular_multiplier: RTL and testbench

- Computes Z = (A * B) mod p using MSB-first interleaved shift-and-add, one multiplier bit per clock.
- Forward counterpart of the modular inverse unit in the ECC scalar-multiplication datapath.
- The point add/double controller uses it for field products, and it verifies inverses: A * inv(A) mod p = 1.
- Uses the same enable / result_ready handshake style as the inverse unit, so the controller can drive both identically.

---
 rtl/modular_multiplier.sv | 105 ++++++++++
 tb/tb_modular_multiplier.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modular_multiplier.sv
// Modular multiplier Z = (A * B) mod p, MSB-first interleaved shift-and-add,
// one multiplier bit per clock. Shares the enable/result_ready handshake of the inverse unit.
module modular_multiplier #(
   parameter int n = 231
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [n-1:0] p,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   output logic [n-1:0] Z,
   output logic         result_ready,
   output logic         busy,
   output logic [1:0]   state_dbg
);

   // Handshake: enable is sampled only in IDLE; the operands are captured on that edge
   // and may change afterwards. result_ready is a one-cycle registered pulse that marks
   // Z valid, and Z holds that value until the next result. Enable while busy is dropped.

   localparam int CW = (n > 1) ? $clog2(n) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [n-1:0]  r;
   logic [n-1:0]  al;
   logic [n-1:0]  bl;
   logic [n-1:0]  pl;
   logic [CW-1:0] i;

   logic [n:0]    pe;
   logic [n:0]    t_dbl;
   logic [n:0]    t_dbl_red;
   logic [n:0]    t_add;
   logic [n:0]    t_add_red;
   logic [n-1:0]  r_next;
   logic          unused_t_msb;

   assign state_dbg = state;
   assign pe        = {1'b0, pl};

   // R < p keeps every intermediate below 2p, so one conditional subtract per step suffices.
   always_comb begin
      t_dbl     = {r, 1'b0};
      t_dbl_red = (t_dbl >= pe) ? (t_dbl - pe) : t_dbl;
      t_add     = bl[i] ? (t_dbl_red + {1'b0, al}) : t_dbl_red;
      t_add_red = (t_add >= pe) ? (t_add - pe) : t_add;
   end

   assign r_next       = t_add_red[n-1:0];
   assign unused_t_msb = t_add_red[n];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         r            <= '0;
         al           <= '0;
         bl           <= '0;
         pl           <= '0;
         i            <= '0;
         Z            <= '0;
         result_ready <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  al    <= A;
                  bl    <= B;
                  pl    <= p;
                  r     <= '0;
                  i     <= CW'(n - 1);
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               r <= r_next;
               i <= i - CW'(1);
               if (i == '0) begin
                  state <= DONE;
               end
            end
            DONE: begin
               Z            <= r;
               result_ready <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modular_multiplier.sv
// Bench for modular_multiplier: an 8-bit instance for handshake/latency cases and a
// 231-bit instance for random products and inverse pairs, both against a (A*B) mod p model.
module tb_modular_multiplier;

   localparam int NS = 8;
   localparam int NL = 231;
   localparam logic [230:0] P231 = {1'b1, 230'h0} | 231'h1a3f_9c27_5e81_d04b_66c3_2f15_b8e9_07ad;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   rst;
   logic [1:0]   en;
   logic [230:0] a_s[2];
   logic [230:0] b_s[2];
   logic [230:0] p_s[2];

   logic [7:0]   z8;
   logic [230:0] z231;
   logic         rr0, rr1, bsy0, bsy1;
   logic [1:0]   unused_st8, unused_st231;
   logic [1:0]   rr_v, bsy_v;
   logic [230:0] z_v[2];

   assign rr_v   = {rr1, rr0};
   assign bsy_v  = {bsy1, bsy0};
   assign z_v[0] = {223'b0, z8};
   assign z_v[1] = z231;

   int errors = 0;
   int checks = 0;
   int shown  = 0;

   modular_multiplier #(.n(NS)) dut8 (
      .clk(clk), .reset(rst[0]), .enable(en[0]),
      .p(p_s[0][7:0]), .A(a_s[0][7:0]), .B(b_s[0][7:0]),
      .Z(z8), .result_ready(rr0), .busy(bsy0), .state_dbg(unused_st8)
   );

   modular_multiplier #(.n(NL)) dut231 (
      .clk(clk), .reset(rst[1]), .enable(en[1]),
      .p(p_s[1]), .A(a_s[1]), .B(b_s[1]),
      .Z(z231), .result_ready(rr1), .busy(bsy1), .state_dbg(unused_st231)
   );

   task automatic chk(input string name, input logic [230:0] act, input logic [230:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (shown < 40) begin
            shown++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
         end
      end
   endtask

   function automatic logic [230:0] mulmod(input logic [230:0] a, input logic [230:0] b,
                                           input logic [230:0] m);
      logic [461:0] pr;
      pr = ({231'b0, a} * {231'b0, b}) % {231'b0, m};
      return pr[230:0];
   endfunction

   // Extended Euclid with coefficients kept mod m; ok is set when gcd(a, m) == 1.
   function automatic logic [230:0] inv_mod(input logic [230:0] a, input logic [230:0] m,
                                            output bit ok);
      logic [461:0] r0, r1, t0, t1, q, tmp, mm;
      mm = {231'b0, m};
      r0 = mm;
      r1 = {231'b0, a};
      t0 = '0;
      t1 = 462'd1;
      for (int k = 0; k < 1000 && r1 != 0; k++) begin
         q   = r0 / r1;
         tmp = r0 % r1;
         r0  = r1;
         r1  = tmp;
         tmp = (t0 + mm - ((q * t1) % mm)) % mm;
         t0  = t1;
         t1  = tmp;
      end
      ok = (r0 == 462'd1);
      return t0[230:0];
   endfunction

   function automatic logic [230:0] rnd_below(input logic [230:0] m);
      logic [255:0] x;
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      x = x % {25'b0, m};
      return x[230:0];
   endfunction

   // Reference model: one product in flight per instance; result due n+1 edges after acceptance.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int N = (g == 0) ? NS : NL;
      bit           active   = 1'b0;
      bit           exp_rr   = 1'b0;
      bit           exp_busy = 1'b0;
      int           lc       = 0;
      int           acc_c    = 0;
      logic [230:0] pend     = '0;
      logic [230:0] exp_z    = '0;

      always @(posedge clk or negedge rst[g]) begin
         if (!rst[g]) begin
            active   = 1'b0;
            exp_rr   = 1'b0;
            exp_busy = 1'b0;
            exp_z    = '0;
         end else begin
            lc++;
            exp_rr = 1'b0;
            if (!active) begin
               if (en[g]) begin
                  active = 1'b1;
                  acc_c  = lc;
                  pend   = mulmod(a_s[g], b_s[g], p_s[g]);
               end
            end else if (lc == acc_c + N + 1) begin
               active = 1'b0;
               exp_z  = pend;
               exp_rr = 1'b1;
            end
            exp_busy = active;
         end
      end

      always @(negedge clk) begin
         if (rst[g]) begin
            chk($sformatf("rr%0d", N), {230'b0, rr_v[g]}, {230'b0, exp_rr});
            chk($sformatf("busy%0d", N), {230'b0, bsy_v[g]}, {230'b0, exp_busy});
            chk($sformatf("z%0d", N), z_v[g], exp_z);
         end
      end
   end

   task automatic start(input int g, input logic [230:0] a, input logic [230:0] b,
                        input logic [230:0] m);
      @(negedge clk);
      a_s[g] = a;
      b_s[g] = b;
      p_s[g] = m;
      en[g]  = 1'b1;
   endtask

   task automatic wait_rr(input int g, input int lim, input bit drop, output int lat,
                          output int bcnt);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      bcnt = 0;
      for (int c = 1; c <= lim && !seen; c++) begin
         @(negedge clk);
         if (drop) en[g] = 1'b0;
         if (bsy_v[g]) bcnt++;
         if (rr_v[g]) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      chk("rr_timeout", {230'b0, seen}, 231'd1);
   endtask

   task automatic op(input int g, input logic [230:0] a, input logic [230:0] b,
                     input logic [230:0] m, output int lat, output int bcnt);
      start(g, a, b, m);
      wait_rr(g, (g == 0) ? NS + 8 : NL + 8, 1'b1, lat, bcnt);
   endtask

   initial begin
      int lat, bc, cnt;
      bit ok;
      logic [230:0] a, b, inv;

      rst = 2'b11;
      en  = 2'b00;
      for (int g = 0; g < 2; g++) begin
         a_s[g] = '0;
         b_s[g] = '0;
         p_s[g] = '0;
      end
      #1 rst = 2'b00;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("reset_z", z_v[g], '0);
         chk("reset_rr", {230'b0, rr_v[g]}, '0);
         chk("reset_busy", {230'b0, bsy_v[g]}, '0);
      end
      @(negedge clk);
      rst = 2'b11;

      // Single product: latency and busy length
      op(0, 3, 5, 251, lat, bc);
      chk("latency", lat, 10);
      chk("busy_len", bc, 9);
      chk("z_3x5", z_v[0], 15);
      op(0, 250, 250, 251, lat, bc);
      chk("z_250x250", z_v[0], 1);
      op(0, 2, 126, 251, lat, bc);
      chk("z_2x126", z_v[0], 1);
      op(0, 0, 200, 251, lat, bc);
      chk("z_0x200", z_v[0], 0);
      op(0, 200, 0, 251, lat, bc);
      chk("z_200x0", z_v[0], 0);

      // Enable during RUN with new operands is ignored
      start(0, 3, 5, 251);
      @(negedge clk);
      en[0] = 1'b0;
      repeat (2) @(negedge clk);
      a_s[0] = 7;
      b_s[0] = 7;
      en[0]  = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      wait_rr(0, NS + 8, 1'b1, lat, bc);
      chk("z_ignore", z_v[0], 15);
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (rr_v[0]) cnt++;
      end
      chk("no_second_rr", cnt, 0);

      // Asynchronous reset in RUN cycle 4
      start(0, 3, 5, 251);
      @(negedge clk);
      en[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst[0] = 1'b0;
      #1;
      chk("abort_z", z_v[0], 0);
      chk("abort_busy", {230'b0, bsy_v[0]}, 0);
      chk("abort_rr", {230'b0, rr_v[0]}, 0);
      @(negedge clk);
      rst[0] = 1'b1;
      op(0, 10, 30, 251, lat, bc);
      chk("z_10x30", z_v[0], 49);

      // Enable held high: one result every n+2 cycles
      start(0, 100, 100, 251);
      for (int k = 0; k < 3; k++) begin
         wait_rr(0, NS + 8, 1'b0, lat, bc);
         chk("b2b_period", lat, 10);
         chk("b2b_z", z_v[0], 211);
      end
      en[0] = 1'b0;
      repeat (4) @(negedge clk);

      // Wide instance: boundaries, random products, inverse pairs
      op(1, P231 - 231'd1, P231 - 231'd1, P231, lat, bc);
      chk("wide_m1xm1", z_v[1], 1);
      op(1, 1, P231 - 231'd1, P231, lat, bc);
      chk("wide_1xm1", z_v[1], P231 - 231'd1);
      chk("wide_latency", lat, NL + 2);
      for (int k = 0; k < 150; k++) begin
         a = rnd_below(P231);
         b = rnd_below(P231);
         op(1, a, b, P231, lat, bc);
      end
      for (int k = 0; k < 5; k++) begin
         a   = rnd_below(P231);
         inv = inv_mod(a, P231, ok);
         if (ok) begin
            chk("inv_model", mulmod(a, inv, P231), 1);
            op(1, a, inv, P231, lat, bc);
            chk("inv_z", z_v[1], 1);
         end
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
